ram_fifo_shim: RTL and testbench

Buffered, parametrised successor to the raster RAM shim. It accepts signed samples on a commit/finished handshake into an internal FIFO and drains them asynchronously to a LiteX DMA write port as one or more RAM words per sample, sign-extended. It advances a ring-buffer byte offset above `BASE_ADDR` and reports the current head address to the kernel on request. It sits between the raster sample source and the LiteX RAM DMA, or the simulator shim.

---
 rtl/ram_fifo_shim.sv | 276 +++++++++++++++++++++++++++
 tb/tb_ram_fifo_shim.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_shim.sv
// ram_fifo_shim: buffered bridge from a raster sample source to a LiteX DMA
// write port. Signed samples enter through a commit/finished handshake into a
// FIFO. They are drained as one or more sign-extended RAM words per sample,
// least significant word first, into a byte-addressed ring above BASE_ADDR.
// The current head address can be captured on request.
//
// Optional build macro: RAM_FIFO_SHIM_DROP_EN. When it is defined, a commit
// that arrives while the FIFO is full is acknowledged but the sample is
// discarded and counted on `dropped`. When it is not defined, such a commit
// stalls until space frees up, and the `dropped` port is absent.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   data, commit        signed sample and level enqueue request
//   finished            sample accepted; held until commit drops
//   read_end_req_off    kernel head-address request (level)
//   read_end_addr       captured head address
//   read_end_req_valid  read_end_addr is valid
//   word, addr, write   DMA write data, byte address and strobe
//   valid               DMA write acknowledge
//   fifo_level          entries not yet fully written
//   dropped             discarded-sample count (DROP_EN builds only)
module ram_fifo_shim #(
    parameter int unsigned BASE_ADDR       = 32'h1000000,
    parameter int          MAX_BYTE_WID    = 13,
    parameter int          DAT_WID         = 24,
    parameter int          RAM_WORD        = 16,
    parameter int          RAM_WID         = 32,
    parameter int          FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DAT_WID-1:0]         data,
    input  logic                       commit,
    output logic                       finished,
    input  logic                       read_end_req_off,
    output logic [RAM_WID-1:0]         read_end_addr,
    output logic                       read_end_req_valid,
    output logic [RAM_WORD-1:0]        word,
    output logic [RAM_WID-1:0]         addr,
    output logic                       write,
    input  logic                       valid,
`ifdef RAM_FIFO_SHIM_DROP_EN
    output logic [15:0]                dropped,
`endif
    output logic [FIFO_DEPTH_LOG2:0]   fifo_level
);

    localparam int WORDS = (DAT_WID + RAM_WORD - 1) / RAM_WORD;
    localparam int STEP  = RAM_WORD / 8;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int EXT_W = 4 * RAM_WORD;
    localparam int LVL_W = FIFO_DEPTH_LOG2 + 1;

    // Word k of the sample after sign extension to the widest supported size.
    function automatic logic [RAM_WORD-1:0] word_sel(
        input logic signed [DAT_WID-1:0] s,
        input logic [1:0]                k
    );
        logic signed [EXT_W-1:0] e;
        e = s;
        return e[int'(k)*RAM_WORD +: RAM_WORD];
    endfunction

`ifdef RAM_FIFO_SHIM_DROP_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`endif

    // ---------------- FIFO storage ----------------
    logic signed [DAT_WID-1:0]    mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0]   wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0]   rd_ptr;
    logic                         push;
    logic                         pop;
    logic                         full;
    logic                         empty;

    assign full  = (fifo_level == LVL_W'(DEPTH));
    assign empty = (fifo_level == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= $signed(data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_DEPTH_LOG2'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // ---------------- input handshake FSM ----------------
    typedef enum logic {IN_IDLE, IN_ACK} in_state_t;

    in_state_t in_state;
    in_state_t in_state_nxt;
    logic      finished_nxt;
`ifdef RAM_FIFO_SHIM_DROP_EN
    logic      drop;
`endif

    always_comb begin
        in_state_nxt = in_state;
        finished_nxt = finished;
        push         = 1'b0;
`ifdef RAM_FIFO_SHIM_DROP_EN
        drop         = 1'b0;
`endif
        case (in_state)
            IN_IDLE: begin
                if (commit) begin
                    if (!full) begin
                        push         = 1'b1;
                        finished_nxt = 1'b1;
                        in_state_nxt = IN_ACK;
                    end
`ifdef RAM_FIFO_SHIM_DROP_EN
                    else begin
                        drop         = 1'b1;
                        finished_nxt = 1'b1;
                        in_state_nxt = IN_ACK;
                    end
`endif
                end
            end
            IN_ACK: begin
                // One sample per commit assertion: wait for commit to drop.
                if (!commit) begin
                    finished_nxt = 1'b0;
                    in_state_nxt = IN_IDLE;
                end
            end
            default: in_state_nxt = IN_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_state <= IN_IDLE;
            finished <= 1'b0;
        end else begin
            in_state <= in_state_nxt;
            finished <= finished_nxt;
        end
    end

`ifdef RAM_FIFO_SHIM_DROP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            dropped <= '0;
        end else if (drop) begin
            dropped <= sat_inc16(dropped);
        end
    end
`endif

    // ---------------- DMA writer FSM ----------------
    typedef enum logic [1:0] {WR_POP, WR_STROBE, WR_GAP} wr_state_t;

    wr_state_t                 wr_state;
    wr_state_t                 wr_state_nxt;
    logic signed [DAT_WID-1:0] sample_p0;
    logic                      latch;
    logic [1:0]                k;
    logic [1:0]                k_nxt;
    logic                      sample_done;
    logic                      sample_done_nxt;
    logic                      write_nxt;
    logic [RAM_WORD-1:0]       word_nxt;
    logic [MAX_BYTE_WID-1:0]   offset;
    logic [MAX_BYTE_WID-1:0]   offset_nxt;

    always_comb begin
        wr_state_nxt    = wr_state;
        k_nxt           = k;
        sample_done_nxt = sample_done;
        write_nxt       = write;
        word_nxt        = word;
        offset_nxt      = offset;
        latch           = 1'b0;
        pop             = 1'b0;
        case (wr_state)
            WR_POP: begin
                if (!empty) begin
                    latch           = 1'b1;
                    k_nxt           = 2'd0;
                    sample_done_nxt = 1'b0;
                    wr_state_nxt    = WR_STROBE;
                end
            end
            WR_STROBE: begin
                // First STROBE cycle loads word and raises write; the strobe
                // then holds with word/addr stable until acknowledged.
                if (!write) begin
                    write_nxt = 1'b1;
                    word_nxt  = word_sel(sample_p0, k);
                end else if (valid) begin
                    write_nxt    = 1'b0;
                    offset_nxt   = offset + MAX_BYTE_WID'(STEP);
                    wr_state_nxt = WR_GAP;
                    if (k == 2'(WORDS - 1)) begin
                        // The entry stays counted in fifo_level until its
                        // last word is acknowledged.
                        pop             = 1'b1;
                        sample_done_nxt = 1'b1;
                    end else begin
                        k_nxt = k + 2'd1;
                    end
                end
            end
            WR_GAP: begin
                wr_state_nxt = sample_done ? WR_POP : WR_STROBE;
            end
            default: wr_state_nxt = WR_POP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (latch) begin
            sample_p0 <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state    <= WR_POP;
            k           <= 2'd0;
            sample_done <= 1'b0;
            write       <= 1'b0;
            word        <= '0;
            offset      <= '0;
            addr        <= RAM_WID'(BASE_ADDR);
        end else begin
            wr_state    <= wr_state_nxt;
            k           <= k_nxt;
            sample_done <= sample_done_nxt;
            write       <= write_nxt;
            word        <= word_nxt;
            offset      <= offset_nxt;
            addr        <= RAM_WID'(BASE_ADDR) + RAM_WID'(offset_nxt);
        end
    end

    // ---------------- head-address request ----------------
    // The captured value is frozen while valid is high, so the kernel reads a
    // stable address even as later words advance the ring offset.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_end_req_valid <= 1'b0;
            read_end_addr      <= '0;
        end else if (!read_end_req_off) begin
            read_end_req_valid <= 1'b0;
        end else if (!read_end_req_valid) begin
            read_end_addr      <= addr;
            read_end_req_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ram_fifo_shim.sv
module tb_ram_fifo_shim;

    localparam logic [31:0] BASE = 32'h1000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance: DAT_WID=24, RAM_WORD=16 -> two words per sample
    logic        rst = 1'b1;
    logic [23:0] data = '0;
    logic        commit = 1'b0;
    logic        finished;
    logic        req = 1'b0;
    logic [31:0] read_end_addr;
    logic        req_valid;
    logic [15:0] word;
    logic [31:0] addr;
    logic        write;
    logic        valid = 1'b0;
    logic [4:0]  fifo_level;
`ifdef RAM_FIFO_SHIM_DROP_EN
    logic [15:0] dropped;
    logic [15:0] dropped_w;
`endif

    // wrap instance: DAT_WID=16, MAX_BYTE_WID=4 -> 8 words per ring
    logic [15:0] data_w = '0;
    logic        commit_w = 1'b0;
    logic        finished_w;
    logic        req_w = 1'b0;
    logic [31:0] rea_w;
    logic        req_valid_w;
    logic [15:0] word_w;
    logic [31:0] addr_w;
    logic        write_w;
    logic        valid_w = 1'b1;
    logic [4:0]  level_w;

    ram_fifo_shim dut (
        .clk               (clk),
        .rst               (rst),
        .data              (data),
        .commit            (commit),
        .finished          (finished),
        .read_end_req_off  (req),
        .read_end_addr     (read_end_addr),
        .read_end_req_valid(req_valid),
        .word              (word),
        .addr              (addr),
        .write             (write),
        .valid             (valid),
`ifdef RAM_FIFO_SHIM_DROP_EN
        .dropped           (dropped),
`endif
        .fifo_level        (fifo_level)
    );

    ram_fifo_shim #(.DAT_WID(16), .MAX_BYTE_WID(4)) dut_w (
        .clk               (clk),
        .rst               (rst),
        .data              (data_w),
        .commit            (commit_w),
        .finished          (finished_w),
        .read_end_req_off  (req_w),
        .read_end_addr     (rea_w),
        .read_end_req_valid(req_valid_w),
        .word              (word_w),
        .addr              (addr_w),
        .write             (write_w),
        .valid             (valid_w),
`ifdef RAM_FIFO_SHIM_DROP_EN
        .dropped           (dropped_w),
`endif
        .fifo_level        (level_w)
    );

    int total = 0;
    int bad   = 0;

    // writes seen on the wrap instance (valid_w is tied high)
    logic [31:0] waddr [16];
    logic [15:0] wword [16];
    int          nw = 0;

    always @(negedge clk) begin
        if (write_w === 1'b1 && nw < 16) begin
            waddr[nw] = addr_w;
            wword[nw] = word_w;
            nw = nw + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        commit = 1'b0;
        valid  = 1'b0;
        req    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_fin(input logic lvl, input string tag);
        int n = 0;
        while (finished !== lvl && n < 40) begin
            tick();
            n++;
        end
        if (finished !== lvl) chk(tag, 64'(finished), 64'(lvl));
    endtask

    task automatic commit_sample(input logic [23:0] d);
        data   = d;
        commit = 1'b1;
        wait_fin(1'b1, "commit_timeout");
        commit = 1'b0;
        wait_fin(1'b0, "release_timeout");
    endtask

    task automatic ack_word(input logic [15:0] ew, input logic [31:0] ea, input string tag);
        int n = 0;
        while (write !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_word"}, 64'(word), 64'(ew));
        chk({tag, "_addr"}, 64'(addr), 64'(ea));
        valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    initial begin
        // ---- reset state ----
        do_reset();
        chk("rst_finished", 64'(finished), 64'(0));
        chk("rst_write", 64'(write), 64'(0));
        chk("rst_word", 64'(word), 64'(0));
        chk("rst_req_valid", 64'(req_valid), 64'(0));
        chk("rst_read_end_addr", 64'(read_end_addr), 64'(0));
        chk("rst_level", 64'(fifo_level), 64'(0));
        chk("rst_addr", 64'(addr), 64'(BASE));

        // ---- single sample, valid tied high, cycle-exact ----
        valid  = 1'b1;
        data   = 24'h800001;
        commit = 1'b1;
        tick();
        chk("t1_finished", 64'(finished), 64'(1));
        chk("t1_level_push", 64'(fifo_level), 64'(1));
        chk("t1_write_e0", 64'(write), 64'(0));
        tick();
        chk("t1_write_e1", 64'(write), 64'(0));
        tick();
        chk("t1_write_w0", 64'(write), 64'(1));
        chk("t1_word_w0", 64'(word), 64'(16'h0001));
        chk("t1_addr_w0", 64'(addr), 64'(BASE));
        tick();
        chk("t1_write_low", 64'(write), 64'(0));
        chk("t1_addr_step", 64'(addr), 64'(BASE + 2));
        tick();
        chk("t1_write_gap", 64'(write), 64'(0));
        tick();
        chk("t1_write_w1", 64'(write), 64'(1));
        chk("t1_word_w1", 64'(word), 64'(16'hFF80));
        chk("t1_addr_w1", 64'(addr), 64'(BASE + 2));
        chk("t1_finished_held", 64'(finished), 64'(1));
        chk("t1_level_held", 64'(fifo_level), 64'(1));
        tick();
        chk("t1_write_done", 64'(write), 64'(0));
        chk("t1_level_pop", 64'(fifo_level), 64'(0));
        commit = 1'b0;
        tick();
        chk("t1_finished_clr", 64'(finished), 64'(0));
        valid = 1'b0;

        // ---- head request after three acknowledged words ----
        do_reset();
        commit_sample(24'h123456);
        commit_sample(24'hFEDCBA);
        ack_word(16'h3456, BASE, "hd_a0");
        ack_word(16'h0012, BASE + 2, "hd_a1");
        chk("hd_level_after_pop", 64'(fifo_level), 64'(1));
        ack_word(16'hDCBA, BASE + 4, "hd_b0");
        req = 1'b1;
        tick();
        chk("hd_valid_rise", 64'(req_valid), 64'(1));
        chk("hd_addr", 64'(read_end_addr), 64'(BASE + 6));
        ack_word(16'hFFFE, BASE + 6, "hd_b1");
        tick();
        chk("hd_addr_stable", 64'(read_end_addr), 64'(BASE + 6));
        chk("hd_valid_held", 64'(req_valid), 64'(1));
        chk("hd_level_empty", 64'(fifo_level), 64'(0));
        req = 1'b0;
        tick();
        chk("hd_valid_clr", 64'(req_valid), 64'(0));

        // ---- FIFO full with valid held low ----
        do_reset();
        for (int i = 0; i < 16; i++) begin
            commit_sample(24'(i + 1));
        end
        chk("full_level", 64'(fifo_level), 64'(16));
        data   = 24'hABCDEF;
        commit = 1'b1;
        for (int i = 0; i < 4; i++) tick();
`ifdef RAM_FIFO_SHIM_DROP_EN
        chk("full_drop_finished", 64'(finished), 64'(1));
        chk("full_dropped", 64'(dropped), 64'(1));
        chk("full_drop_level", 64'(fifo_level), 64'(16));
        commit = 1'b0;
        tick();
`else
        chk("full_stall_finished", 64'(finished), 64'(0));
        chk("full_stall_level", 64'(fifo_level), 64'(16));
        ack_word(16'h0001, BASE, "full_s0w0");
        ack_word(16'h0000, BASE + 2, "full_s0w1");
        chk("full_pop_finished", 64'(finished), 64'(0));
        chk("full_pop_level", 64'(fifo_level), 64'(15));
        tick();
        chk("full_accept_finished", 64'(finished), 64'(1));
        chk("full_accept_level", 64'(fifo_level), 64'(16));
        commit = 1'b0;
        tick();
`endif

        // ---- reset during the strobe of word 1 ----
        do_reset();
        commit_sample(24'h000123);
        ack_word(16'h0123, BASE, "mid_w0");
        begin
            int n = 0;
            while (write !== 1'b1 && n < 40) begin
                tick();
                n++;
            end
        end
        chk("mid_strobe_w1", 64'(write), 64'(1));
        rst = 1'b1;
        tick();
        chk("mid_write", 64'(write), 64'(0));
        chk("mid_level", 64'(fifo_level), 64'(0));
        chk("mid_addr", 64'(addr), 64'(BASE));
        rst = 1'b0;
        commit_sample(24'h000042);
        ack_word(16'h0042, BASE, "post_w0");
        ack_word(16'h0000, BASE + 2, "post_w1");
        chk("post_level", 64'(fifo_level), 64'(0));

        // ---- ring wrap on the 16-byte instance ----
        do_reset();
        for (int i = 0; i < 9; i++) begin
            int n = 0;
            data_w   = 16'h0100 + 16'(i);
            commit_w = 1'b1;
            while (finished_w !== 1'b1 && n < 40) begin
                tick();
                n++;
            end
            commit_w = 1'b0;
            n = 0;
            while (finished_w !== 1'b0 && n < 40) begin
                tick();
                n++;
            end
        end
        begin
            int n = 0;
            while (nw < 9 && n < 200) begin
                tick();
                n++;
            end
        end
        chk("wrap_count", 64'(nw), 64'(9));
        chk("wrap_first_addr", 64'(waddr[0]), 64'(BASE));
        chk("wrap_8th_addr", 64'(waddr[7]), 64'(BASE + 14));
        chk("wrap_9th_addr", 64'(waddr[8]), 64'(BASE));
        chk("wrap_9th_word", 64'(wword[8]), 64'(16'h0108));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
